// File: rtl/fir_channel_scheduler_if.sv
// Bundles the sample-side, engine-side and result-side signals of the FIR channel scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding system's.
interface fir_channel_scheduler_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  localparam int unsigned CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      fir_valid_in;
  logic [WIDTH-1:0]          fir_data_in;
  logic [CW-1:0]             fir_ch;
  logic                      fir_valid_out;
  logic [WIDTH-1:0]          fir_data_out;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_ch;
  logic                      busy;
  logic [CHANNELS-1:0]       overrun;
  logic                      timeout_err;

  modport slave (
    input  in_valid, in_data, fir_valid_out, fir_data_out,
    output fir_valid_in, fir_data_in, fir_ch, out_valid, out_data, out_ch,
           busy, overrun, timeout_err
  );

  modport master (
    output in_valid, in_data, fir_valid_out, fir_data_out,
    input  fir_valid_in, fir_data_in, fir_ch, out_valid, out_data, out_ch,
           busy, overrun, timeout_err
  );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR engine between CHANNELS sample streams, one sample
// in flight at a time, with per-channel overrun flags and an engine response timeout.
module fir_channel_scheduler #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TIMEOUT  = 63
) (
  input logic                   clk,
  input logic                   rst,
  fir_channel_scheduler_if.slave bus
);
  localparam int unsigned CW = $clog2(CHANNELS);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e                          state_q;
  logic [CHANNELS-1:0]             pend_valid_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  pend_data_q;
  logic [CW-1:0]                   rr_ptr_q;
  logic [TW-1:0]                   wait_cnt_q;
  logic                            fir_valid_q;
  logic [WIDTH-1:0]                fir_data_q;
  logic [CW-1:0]                   fir_ch_q;
  logic                            out_valid_q;
  logic [WIDTH-1:0]                out_data_q;
  logic [CW-1:0]                   out_ch_q;
  logic [CHANNELS-1:0]             overrun_q;
  logic                            timeout_q;

  logic          grant_found;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] rr_next;
  logic          grant;

  // Scan downward so the last hit is the first pending channel at or above rr_ptr.
  always_comb begin
    int unsigned   sum;
    logic [CW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    idx         = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      sum = int'(rr_ptr_q) + i;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      idx = CW'(sum);
      if (pend_valid_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign rr_next = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
  assign grant   = (state_q == StIdle) && grant_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pend_valid_q <= '0;
      pend_data_q  <= '0;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      fir_valid_q  <= 1'b0;
      fir_data_q   <= '0;
      fir_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      overrun_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      // A strobe on the channel being granted refills its slot without counting as overrun.
      for (int c = 0; c < CHANNELS; c++) begin
        if (grant && (grant_idx == CW'(c))) begin
          pend_valid_q[c] <= bus.in_valid[c];
        end else if (bus.in_valid[c]) begin
          pend_valid_q[c] <= 1'b1;
          if (pend_valid_q[c]) overrun_q[c] <= 1'b1;
        end
        if (bus.in_valid[c]) pend_data_q[c] <= bus.in_data[c*WIDTH +: WIDTH];
      end

      fir_valid_q <= 1'b0;
      out_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            fir_data_q  <= pend_data_q[grant_idx];
            fir_ch_q    <= grant_idx;
            rr_ptr_q    <= rr_next;
            fir_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q + TW'(1);
          if (bus.fir_valid_out) begin
            out_data_q  <= bus.fir_data_out;
            out_ch_q    <= fir_ch_q;
            out_valid_q <= 1'b1;
            state_q     <= StDeliver;
          end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StDeliver: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fir_valid_in = fir_valid_q;
  assign bus.fir_data_in  = fir_data_q;
  assign bus.fir_ch       = fir_ch_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_q;
endmodule
